// File: rtl/interval_timer_if.sv
// FSM <-> interval timer handshake: start/value in, expired/busy/remaining out.
// Optional hold input exists only when TIMER_HOLD_EN is defined.
interface interval_timer_if;
  logic       start_timer;
  logic [3:0] value;
`ifdef TIMER_HOLD_EN
  logic       hold;
`endif
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

`ifdef TIMER_HOLD_EN
  modport master (output start_timer, value, hold, input expired, busy, remaining);
  modport slave  (input start_timer, value, hold, output expired, busy, remaining);
`else
  modport master (output start_timer, value, input expired, busy, remaining);
  modport slave  (input start_timer, value, output expired, busy, remaining);
`endif
endinterface

// File: rtl/interval_timer.sv
// Whole-second countdown timer fed by the interval-parameter store.
// Optional feature macro: TIMER_HOLD_EN (adds a hold input that freezes COUNT).
module interval_timer #(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int PRESC_W     = 26
) (
  input  logic              clk,
  input  logic              sys_reset,
  interval_timer_if.slave   tif
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, EXPIRE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(CLK_PER_SEC - 1);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         rem_q, rem_d;
  logic               expired_q, expired_d;
  logic               busy_q, busy_d;
  logic               hold_w;

`ifdef TIMER_HOLD_EN
  assign hold_w = tif.hold;
`else
  assign hold_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    // A start request wins over everything and leaves the counters untouched.
    if (tif.start_timer) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          rem_d   = tif.value;
          presc_d = PRESC_RELOAD;
          state_d = (tif.value == 4'd0) ? EXPIRE : COUNT;
        end
        COUNT: begin
          if (!hold_w) begin
            if (presc_q != '0) begin
              presc_d = presc_q - PRESC_W'(1);
            end else if (rem_q > 4'd1) begin
              rem_d   = rem_q - 4'd1;
              presc_d = PRESC_RELOAD;
            end else begin
              rem_d   = 4'd0;
              state_d = EXPIRE;
            end
          end
        end
        EXPIRE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    expired_d = (state_d == EXPIRE);
    busy_d    = (state_d == LOAD) || (state_d == COUNT);
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      rem_q     <= 4'd0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
    end
  end

  assign tif.expired   = expired_q;
  assign tif.busy      = busy_q;
  assign tif.remaining = rem_q;

endmodule
